// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-master RAM arbiter: state encoding, bus
// request fields and the round-robin pick.
package ram_arbiter_pkg;

    localparam int unsigned   TIMEOUT_DEFAULT  = 16;
    localparam logic [31:0]   ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    // Request fields carried from a master to the RAM while it is granted.
    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Returns the master index to grant; on a tie the one not served last wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? ~last : v1;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between two masters,
// with a watchdog that force-completes accesses the RAM never answers.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic        timeout
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        grant_q;
    logic        last_q;
    logic [7:0]  cnt_q;

    bus_req_t    m0_req;
    bus_req_t    m1_req;
    bus_req_t    sel_req;
    logic        busy;
    logic        expired;
    logic        done;
    logic [31:0] rsp_data;

    assign m0_req = '{wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
    assign m1_req = '{wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

    always_comb begin
        busy     = (state_q == StBusy);
        sel_req  = grant_q ? m1_req : m0_req;
        // Ready from the RAM only counts while an access is outstanding.
        expired  = busy && !s_ready && (cnt_q == CntLast);
        done     = busy && (s_ready || expired);
        rsp_data = s_ready ? s_rdata : ERR_DATA;

        s_valid  = busy;
        s_wstrb  = busy ? sel_req.wstrb : 4'b0000;
        s_addr   = busy ? sel_req.addr  : m0_addr;
        s_wdata  = busy ? sel_req.wdata : m0_wdata;

        m0_ready = done && !grant_q;
        m1_ready = done && grant_q;
        m0_rdata = rsp_data;
        m1_rdata = rsp_data;
        timeout  = expired;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m0_valid || m1_valid) begin
                        grant_q <= rr_pick(m0_valid, m1_valid, last_q);
                        cnt_q   <= 8'd0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (done) begin
                        last_q  <= grant_q;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: 1-cycle RAM model plus an in-order
// scoreboard of expected completions.
module tb_ram_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout;

    logic        ram_ready = 1'b0;
    logic        mute = 1'b0;
    logic        force_ready = 1'b0;
    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fails = 0;
    int cyc = 0;

    typedef struct {
        logic        m;
        logic [31:0] rdata;
        logic        chk;
        logic        to;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered ready echo of s_valid and read-before-write data.
    assign s_ready = ram_ready | force_ready;
    always @(posedge clk) begin
        ram_ready <= s_valid && !mute;
        s_rdata   <= mem[s_addr[7:2]];
        if (s_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("grant", {30'b0, m1_ready, m0_ready}, mon_e.m ? 32'd2 : 32'd1);
                if (mon_e.chk) check("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.rdata);
                check("timeout", {31'b0, timeout}, {31'b0, mon_e.to});
            end
        end else if (!s_valid) begin
            check("idle_wstrb", {28'b0, s_wstrb}, 32'd0);
            check("idle_timeout", {31'b0, timeout}, 32'd0);
        end
    end

    task automatic access(input logic m, input logic [3:0] wstrb, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk, input logic [31:0] rdata,
                          input logic to, input int lat);
        exp_t e;
        int   c0;
        bit   seen;
        e.m = m; e.rdata = rdata; e.chk = chk; e.to = to;
        sb.push_back(e);
        @(posedge clk); #1;
        if (m) begin
            m1_valid = 1'b1; m1_wstrb = wstrb; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_valid = 1'b1; m0_wstrb = wstrb; m0_addr = addr; m0_wdata = wdata;
        end
        c0 = cyc;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = m ? m1_ready : m0_ready;
        end
        check("ready_seen", {31'b0, seen}, 32'd1);
        if (seen) check("latency", 32'(cyc - c0), 32'(lat));
        @(posedge clk); #1;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h1234_5678;
        mem[8] = 32'h1111_1111;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_valid", {31'b0, s_valid}, 32'd0);
        check("rst_s_wstrb", {28'b0, s_wstrb}, 32'd0);
        check("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
        check("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        resetn = 1'b1;

        access(1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 2);

        // Both masters requesting continuously from reset: strict alternation, m0 first.
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e.m = 1'(i % 2); e.chk = 1'b1; e.to = 1'b0;
            e.rdata = (i % 2) ? 32'h1111_1111 : 32'h1234_5678;
            sb.push_back(e);
        end
        m0_wstrb = '0; m0_addr = 32'h10; m0_wdata = '0;
        m1_wstrb = '0; m1_addr = 32'h20; m1_wdata = '0;
        m0_valid = 1'b1; m1_valid = 1'b1;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        m0_valid = 1'b0; m1_valid = 1'b0;
        check("rr_drain", 32'(sb.size()), 32'd0);

        access(1'b1, 4'b0010, 32'h20, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 2);
        access(1'b1, 4'h0, 32'h20, 32'h0, 1'b1, 32'h1111_CC11, 1'b0, 2);
        access(1'b0, 4'hF, 32'h30, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2);
        access(1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);

        mute = 1'b1;
        access(1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, TIMEOUT);
        mute = 1'b0;
        access(1'b1, 4'h0, 32'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 2);

        @(posedge clk); #1;
        force_ready = 1'b1;
        @(negedge clk);
        check("stale_ready", {29'b0, timeout, m1_ready, m0_ready}, 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b0;

        // Reset lands while m1's access is in its first BUSY cycle.
        m1_wstrb = '0; m1_addr = 32'h20; m1_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_before_rst", {31'b0, s_valid}, 32'd1);
        resetn = 1'b0;
        m1_valid = 1'b0;
        @(negedge clk);
        check("rst_busy_ready", {31'b0, m1_ready}, 32'd0);
        @(posedge clk); #1;
        check("rst_busy_s_valid", {31'b0, s_valid}, 32'd0);
        resetn = 1'b1;
        access(1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 32'h1111_CC11, 1'b0, 2);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
